// File: rtl/seg7_scan4.sv
// seg7_scan4: 4-digit multiplexed 7-segment driver with dead-time between digit slots.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg7_scan4 #(
  parameter int PRESCALE_W = 17,
  parameter int DEAD_CYC   = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  g_to_a,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_sel
);
  typedef enum logic {DEAD, ON} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  state_t state, state_nx;
  logic [PRESCALE_W-1:0] cnt, dead_cnt, dead_nx;
  logic [1:0]  idx, idx_nx;
  logic [15:0] data_hold;
  logic [3:0]  dp_hold, blank_hold, blank_eff, nib, an_nx;
  logic [6:0]  seg_nx;
  logic        tick, lit, dp_nx;
  assign tick      = &cnt;
  assign nib       = data_hold[{idx, 2'b00} +: 4];
  assign digit_sel = idx;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
  assign lz[3] = data_hold[15:12] == 4'h0;
  assign lz[2] = lz[3] && data_hold[11:8] == 4'h0;
  assign lz[1] = lz[2] && data_hold[7:4] == 4'h0;
  assign lz[0] = 1'b0;
  assign blank_eff = blank_hold | lz;
`else
  assign blank_eff = blank_hold;
`endif
  always_comb begin
    state_nx = tick ? DEAD
             : (state == DEAD && dead_cnt == PRESCALE_W'(DEAD_CYC - 1)) ? ON : state;
    dead_nx  = tick ? '0 : state == DEAD ? dead_cnt + 1'b1 : dead_cnt;
    idx_nx   = tick ? idx + 2'd1 : idx;
    lit      = state == ON && !blank_eff[idx];
    an_nx    = lit ? ~(4'b0001 << idx) : 4'hF;
    seg_nx   = lit ? SEG_LUT[nib] : 7'h7F;
    dp_nx    = lit ? ~dp_hold[idx] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= DEAD;
      dead_cnt   <= '0;
      data_hold  <= '0;
      dp_hold    <= '0;
      blank_hold <= '0;
      an         <= 4'hF;
      g_to_a     <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      cnt      <= cnt + 1'b1;
      idx      <= idx_nx;
      state    <= state_nx;
      dead_cnt <= dead_nx;
      an       <= an_nx;
      g_to_a   <= seg_nx;
      dp       <= dp_nx;
      if (load) begin
        data_hold  <= data;
        dp_hold    <= dp_in;
        blank_hold <= blank;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: directed checks of seg7_scan4 with PRESCALE_W=4, DEAD_CYC=2.
module tb_seg7_scan4;
  logic        clk = 0, clr_n = 0, load = 0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0, blank = '0;
  logic [6:0]  g_to_a;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  int total = 0, bad = 0, e = 0;
  logic ok;

  seg7_scan4 #(.PRESCALE_W(4), .DEAD_CYC(2)) dut (
    .clk(clk), .clr_n(clr_n), .data(data), .dp_in(dp_in), .blank(blank),
    .load(load), .g_to_a(g_to_a), .an(an), .dp(dp), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic goto(input int n);
    while (e < n) adv(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
    end
  endtask

  initial begin
    load = 1; data = 16'hFFFF; dp_in = 4'hF; blank = 4'h0;
    adv(2);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", g_to_a, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_sel", digit_sel, 2'd0);
    load = 0; dp_in = 0; clr_n = 1; e = 0;
    adv(1);
    chk("e1_an", an, 4'hF);
    data = 16'h7A3F; load = 1;
    adv(1);
    load = 0;
    chk("e2_an", an, 4'hF);
    chk("e2_seg", g_to_a, 7'h7F);
    adv(1);
    chk("e3_an", an, 4'hE);
    chk("e3_seg", g_to_a, 7'h0E);
    chk("e3_dp", dp, 1'b1);
    goto(5);
    chk("e5_an", an, 4'hE);
    data = 16'h7A31; load = 1;
    goto(6);
    load = 0;
    chk("e6_an", an, 4'hE);
    chk("e6_seg", g_to_a, 7'h0E);
    goto(7);
    chk("e7_an", an, 4'hE);
    chk("e7_seg", g_to_a, 7'h79);
    goto(16);
    chk("e16_sel", digit_sel, 2'd1);
    goto(17);
    chk("e17_an", an, 4'hF);
    goto(19);
    chk("e19_an", an, 4'hD);
    chk("e19_seg", g_to_a, 7'h30);
    goto(35);
    chk("e35_an", an, 4'hB);
    chk("e35_seg", g_to_a, 7'h08);
    goto(50);
    chk("e50_an", an, 4'hF);
    goto(51);
    chk("e51_an", an, 4'h7);
    chk("e51_seg", g_to_a, 7'h78);
    goto(63);
    chk("e63_sel", digit_sel, 2'd3);
    goto(64);
    chk("e64_sel", digit_sel, 2'd0);
    dp_in = 4'b0100; blank = 4'b0010; load = 1;
    goto(65);
    load = 0;
    goto(67);
    chk("e67_an", an, 4'hE);
    chk("e67_seg", g_to_a, 7'h79);
    chk("e67_dp", dp, 1'b1);
    goto(80);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      adv(1);
      ok &= (an === 4'hF) && (dp === 1'b1);
    end
    chk("blank_slot", ok, 1'b1);
    goto(99);
    chk("e99_an", an, 4'hB);
    chk("e99_seg", g_to_a, 7'h08);
    chk("e99_dp", dp, 1'b0);
    data = 16'h0005; blank = 4'h0; dp_in = 4'h0; load = 1;
    goto(100);
    load = 0;
    goto(115);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz3_an", an, 4'hF);
`else
    chk("lz3_an", an, 4'h7);
    chk("lz3_seg", g_to_a, 7'h40);
`endif
    goto(131);
    chk("d0_an", an, 4'hE);
    chk("d0_seg", g_to_a, 7'h12);
    goto(147);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz1_an", an, 4'hF);
`else
    chk("lz1_an", an, 4'hD);
    chk("lz1_seg", g_to_a, 7'h40);
`endif
    goto(163);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz2_an", an, 4'hF);
`else
    chk("lz2_an", an, 4'hB);
    chk("lz2_seg", g_to_a, 7'h40);
`endif
    goto(170);
    clr_n = 0; load = 1; data = 16'hFFFF;
    adv(1);
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", g_to_a, 7'h7F);
    chk("mrst_dp", dp, 1'b1);
    chk("mrst_sel", digit_sel, 2'd0);
    clr_n = 1; load = 0; e = 0;
    adv(2);
    chk("r2_an", an, 4'hF);
    adv(1);
    chk("r3_an", an, 4'hE);
    chk("r3_seg", g_to_a, 7'h40);
    chk("r3_dp", dp, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
